// File: rtl/pixel_readout_capture.sv
// Per-pixel ADC capture sequencer: trigger -> convst -> sample, tagged SOF/EOL, buffered onto a valid/ready stream.
// Optional build macro CAPTURE_TEST_PATTERN_EN adds a test_pattern input that bypasses the ADC with {row,col}.
module pixel_readout_capture #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 12,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_busy,
    input  logic              adc_start_trigger,
    input  logic [ADDR_W-1:0] row_addr,
    input  logic [ADDR_W-1:0] col_addr,
    input  logic [ADDR_W-1:0] col_end,
`ifdef CAPTURE_TEST_PATTERN_EN
    input  logic              test_pattern,
`endif
    output logic              adc_convst,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_data_valid,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tuser,
    output logic              m_tlast,
    output logic              overflow,
    output logic              trigger_miss,
    output logic              timeout_err,
    output logic [23:0]       pixel_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = DATA_W + 2;
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_WAIT_DATA
    } state_t;

    state_t              state, state_nxt;
    logic                eol_q;
    logic [TO_W-1:0]     to_cnt;
    logic                frame_busy_q;
    logic                sof_flag;
    logic                wr_req;
    logic [DATA_W-1:0]   wr_data;
    logic                timeout_hit;
    logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W:0]      wr_ptr, rd_ptr;
    logic                fifo_empty, fifo_full, rd_en, wr_en, drop;
    logic                fb_rise, miss_set;
    logic [ENTRY_W-1:0]  head;
`ifdef CAPTURE_TEST_PATTERN_EN
    logic [7:0]          row_lo_q, col_lo_q;
`endif

    assign fb_rise    = frame_busy && !frame_busy_q;
    assign miss_set   = adc_start_trigger && (state != S_IDLE);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign rd_en      = !fifo_empty && m_tready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en      = wr_req && (!fifo_full || rd_en);
    assign drop       = wr_req && !wr_en;

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_nxt   = state;
        adc_convst  = 1'b0;
        wr_req      = 1'b0;
        wr_data     = '0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (adc_start_trigger) state_nxt = S_CONVERT;
            end
            S_CONVERT: begin
`ifdef CAPTURE_TEST_PATTERN_EN
                if (test_pattern) begin
                    wr_req    = 1'b1;
                    wr_data   = DATA_W'({row_lo_q, col_lo_q});
                    state_nxt = S_IDLE;
                end else begin
                    adc_convst = 1'b1;
                    state_nxt  = S_WAIT_DATA;
                end
`else
                adc_convst = 1'b1;
                state_nxt  = S_WAIT_DATA;
`endif
            end
            S_WAIT_DATA: begin
                if (adc_data_valid) begin
                    wr_req    = 1'b1;
                    wr_data   = adc_data;
                    state_nxt = S_IDLE;
                end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    wr_req      = 1'b1;
                    wr_data     = '1;
                    timeout_hit = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            eol_q        <= 1'b0;
            to_cnt       <= '0;
            frame_busy_q <= 1'b0;
            sof_flag     <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow     <= 1'b0;
            trigger_miss <= 1'b0;
            timeout_err  <= 1'b0;
            pixel_count  <= '0;
        end else begin
            state        <= state_nxt;
            frame_busy_q <= frame_busy;
            if (state == S_IDLE && adc_start_trigger)
                eol_q <= (col_addr == col_end);
            if (state == S_CONVERT)
                to_cnt <= '0;
            else if (state == S_WAIT_DATA)
                to_cnt <= to_cnt + TO_W'(1);
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            // A dropped write keeps the SOF tag pending for the next accepted entry.
            if (fb_rise)    sof_flag <= 1'b1;
            else if (wr_en) sof_flag <= 1'b0;
            overflow     <= (overflow     && !fb_rise) || drop;
            trigger_miss <= (trigger_miss && !fb_rise) || miss_set;
            timeout_err  <= (timeout_err  && !fb_rise) || timeout_hit;
            if (fb_rise)
                pixel_count <= '0;
            else if (wr_en && pixel_count != 24'hFFFFFF)
                pixel_count <= pixel_count + 24'd1;
        end
    end

`ifdef CAPTURE_TEST_PATTERN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            row_lo_q <= '0;
            col_lo_q <= '0;
        end else if (state == S_IDLE && adc_start_trigger) begin
            row_lo_q <= row_addr[7:0];
            col_lo_q <= col_addr[7:0];
        end
    end
`endif

    // NOTE: storage is not reset; the pointers define validity and the outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[PTR_W-1:0]] <= {sof_flag, eol_q, wr_data};
    end

    assign head     = mem[rd_ptr[PTR_W-1:0]];
    assign m_tvalid = !fifo_empty;
    assign m_tdata  = m_tvalid ? head[DATA_W-1:0] : '0;
    assign m_tlast  = m_tvalid && head[DATA_W];
    assign m_tuser  = m_tvalid && head[DATA_W+1];

endmodule

// File: tb/tb_pixel_readout_capture.sv
// Scoreboard bench for pixel_readout_capture: a queue-based pixel model predicts every stream beat and sticky flag.
module tb_pixel_readout_capture;
    localparam int DATA_W = 16, ADDR_W = 12, FIFO_DEPTH = 16, TIMEOUT_CYCLES = 64;

    logic clk, rst, frame_busy, adc_start_trigger, adc_convst, adc_data_valid;
    logic [ADDR_W-1:0] row_addr, col_addr, col_end;
    logic [DATA_W-1:0] adc_data, m_tdata;
    logic m_tvalid, m_tready, m_tuser, m_tlast, overflow, trigger_miss, timeout_err;
    logic [23:0] pixel_count;
`ifdef CAPTURE_TEST_PATTERN_EN
    logic test_pattern;
`endif

    pixel_readout_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH),
                            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk(clk), .rst(rst), .frame_busy(frame_busy), .adc_start_trigger(adc_start_trigger),
        .row_addr(row_addr), .col_addr(col_addr), .col_end(col_end),
`ifdef CAPTURE_TEST_PATTERN_EN
        .test_pattern(test_pattern),
`endif
        .adc_convst(adc_convst), .adc_data(adc_data), .adc_data_valid(adc_data_valid),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tuser(m_tuser),
        .m_tlast(m_tlast), .overflow(overflow), .trigger_miss(trigger_miss),
        .timeout_err(timeout_err), .pixel_count(pixel_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int beats = 0, convst_cnt = 0;
    logic [DATA_W+1:0] sb[$];
    bit exp_ovf = 0, exp_miss = 0, exp_to = 0, sof_pend = 0, rand_ready = 0;
    int exp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake beat is popped and compared against the model queue.
    always @(negedge clk) begin
        logic [DATA_W+1:0] e;
        if (!rst && m_tvalid === 1'b1 && m_tready) begin
            beats++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got %0h expected none", {m_tuser, m_tlast, m_tdata});
            end else begin
                e = sb.pop_front();
                check("beat", {14'd0, m_tuser, m_tlast, m_tdata}, {14'd0, e});
            end
        end
    end

    always @(negedge clk) if (adc_convst === 1'b1) convst_cnt++;

    always @(posedge clk) begin
        #1;
        if (rand_ready) m_tready = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        frame_busy = 1'b0;
        tick();
        frame_busy = 1'b1;
        tick();
        tick();
        exp_ovf = 0; exp_miss = 0; exp_to = 0; exp_cnt = 0; sof_pend = 1;
    endtask

    // Model of one write attempt at the coming edge: the FIFO holds FIFO_DEPTH entries,
    // and the queue already reflects any pop at that same edge.
    task automatic expect_write(input logic [DATA_W-1:0] d, input bit eol);
        @(negedge clk);
        #1;
        if (sb.size() < FIFO_DEPTH) begin
            sb.push_back({sof_pend, eol, d});
            sof_pend = 0;
            if (exp_cnt < 24'hFFFFFF) exp_cnt++;
        end else begin
            exp_ovf = 1;
        end
    endtask

    task automatic pixel(input int row, input int col, input int cend, input int lat,
                         input bit respond, input logic [DATA_W-1:0] data);
        row_addr = ADDR_W'(row);
        col_addr = ADDR_W'(col);
        col_end  = ADDR_W'(cend);
        adc_start_trigger = 1'b1;
        tick();
        adc_start_trigger = 1'b0;
        tick();
        if (respond) begin
            repeat (lat) tick();
            adc_data = data;
            adc_data_valid = 1'b1;
            expect_write(data, col == cend);
            tick();
            adc_data_valid = 1'b0;
        end else begin
            repeat (TIMEOUT_CYCLES - 1) tick();
            expect_write('1, col == cend);
            exp_to = 1;
            tick();
        end
    endtask

    task automatic drain(input string name);
        rand_ready = 0;
        m_tready = 1'b1;
        for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
        tick();
        check({name, "_drained"}, sb.size(), 0);
        check({name, "_tvalid_idle"}, m_tvalid, 0);
    endtask

    task automatic check_flags(input string name);
        check({name, "_overflow"}, overflow, exp_ovf);
        check({name, "_trigger_miss"}, trigger_miss, exp_miss);
        check({name, "_timeout_err"}, timeout_err, exp_to);
        check({name, "_pixel_count"}, pixel_count, exp_cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, b0;
        rst = 1'b1; frame_busy = 1'b0; adc_start_trigger = 1'b0; adc_data_valid = 1'b0;
        row_addr = '0; col_addr = '0; col_end = '0; adc_data = '0; m_tready = 1'b1;
`ifdef CAPTURE_TEST_PATTERN_EN
        test_pattern = 1'b0;
`endif
        repeat (4) tick();
        check("rst_convst", adc_convst, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tuser", m_tuser, 0);
        check("rst_tlast", m_tlast, 0);
        check_flags("rst");
        for (int i = 0; i < 10; i++) begin
            adc_start_trigger = 1'b1;
            tick();
            adc_start_trigger = 1'b0;
            tick();
        end
        check("rst_no_convst", convst_cnt, 0);
        check("rst_trigger_miss", trigger_miss, 0);
        rst = 1'b0;
        tick();

        // 3x3 ROI, valid two cycles after each convst.
        frame_start();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                pixel(r, c, 2, 1, 1, DATA_W'($urandom));
        drain("roi");
        check("roi_count9", pixel_count, 9);
        check_flags("roi");

        // Stalled stream: 20 pixels into a 16-entry FIFO.
        frame_start();
        m_tready = 1'b0;
        for (int i = 0; i < 20; i++) pixel(1, i % 4, 3, 0, 1, DATA_W'($urandom));
        check("ovf_set", overflow, 1);
        check("ovf_count16", pixel_count, 16);
        check_flags("ovf");
        b0 = beats;
        drain("ovf");
        check("ovf_beats16", beats - b0, 16);

        // Randomized traffic with random ready and ADC latency.
        frame_start();
        rand_ready = 1;
        for (int i = 0; i < 40; i++)
            pixel($urandom_range(0, 255), $urandom_range(0, 7), 5, $urandom_range(0, 3), 1,
                  DATA_W'($urandom));
        drain("rand");
        check_flags("rand");

        // ADC never responds.
        frame_start();
        pixel(2, 2, 2, 0, 0, '0);
        check("to_set", timeout_err, 1);
        drain("to");
        check_flags("to");
        frame_start();
        check("to_cleared", timeout_err, 0);
        check("to_count_cleared", pixel_count, 0);

        // Second trigger while converting.
        c0 = convst_cnt;
        row_addr = 3; col_addr = 1; col_end = 1;
        adc_start_trigger = 1'b1;
        tick();
        tick();
        adc_start_trigger = 1'b0;
        adc_data = 16'h1234;
        adc_data_valid = 1'b1;
        expect_write(16'h1234, 1);
        tick();
        adc_data_valid = 1'b0;
        exp_miss = 1;
        repeat (3) tick();
        check("miss_one_convst", convst_cnt - c0, 1);
        drain("miss");
        check_flags("miss");

`ifdef CAPTURE_TEST_PATTERN_EN
        c0 = convst_cnt;
        test_pattern = 1'b1;
        row_addr = 5; col_addr = 7; col_end = 9;
        adc_start_trigger = 1'b1;
        tick();
        adc_start_trigger = 1'b0;
        expect_write(16'h0507, 0);
        tick();
        test_pattern = 1'b0;
        drain("tp");
        check("tp_no_convst", convst_cnt - c0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pixel_readout_capture.md
# pixel_readout_capture

Per-pixel ADC capture sequencer at the consuming end of the timing generator's readout interface. It accepts `adc_start_trigger` pulses with the current `row_addr`/`col_addr`, fires an ADC conversion, and waits for the converted sample. Each result is tagged with start-of-frame and end-of-line flags. Samples are buffered in a small FIFO and presented on a valid/ready pixel stream toward the frame buffer / host link.

## Interface
Parameters:
- `DATA_W`, 16, ADC sample width
- `ADDR_W`, 12, row/column address width
- `FIFO_DEPTH`, 16, pixel FIFO entries (power of 2, ≥4)
- `TIMEOUT_CYCLES`, 64, max wait for `adc_data_valid` after `adc_convst`

Ports (clock/reset: one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `frame_busy`  in  1  frame-in-progress from timing generator
- `adc_start_trigger`  in  1  one-cycle per-pixel conversion request
- `row_addr`  in  ADDR_W  row of requested pixel
- `col_addr`  in  ADDR_W  column of requested pixel
- `col_end`  in  ADDR_W  last ROI column (EOL detect)
- `adc_convst`  out  1  one-cycle ADC conversion start
- `adc_data`  in  DATA_W  ADC result
- `adc_data_valid`  in  1  result strobe
- `m_tdata`  out  DATA_W  pixel value
- `m_tvalid`  out  1  stream valid
- `m_tready`  in  1  stream ready
- `m_tuser`  out  1  SOF: first pixel of frame
- `m_tlast`  out  1  EOL: pixel where latched col == `col_end`
- `overflow`  out  1  sticky: sample dropped, FIFO full
- `trigger_miss`  out  1  sticky: trigger while not IDLE
- `timeout_err`  out  1  sticky: ADC did not respond
- `pixel_count`  out  24  FIFO writes this frame, saturating at 24'hFFFFFF

## Operation
- FSM: IDLE → CONVERT → WAIT_DATA → IDLE.
- IDLE: `adc_start_trigger`=1 latches `row_addr`, `col_addr`, EOL = (col_addr == col_end); go CONVERT.
- CONVERT: `adc_convst`=1 for exactly this cycle; clear timeout counter; go WAIT_DATA.
- WAIT_DATA: on `adc_data_valid`, write {sof, eol, adc_data} to FIFO; go IDLE. Counter increments each cycle; on reaching TIMEOUT_CYCLES−1 without valid, write {sof, eol, all-ones}, set `timeout_err`, go IDLE.
- `adc_data_valid` outside WAIT_DATA is ignored.
- Trigger in CONVERT/WAIT_DATA: ignored, `trigger_miss` set.
- SOF flag: set on `frame_busy` rising edge (registered previous value); attached to next FIFO write, then cleared.
- FIFO write while full: entry dropped, `overflow` set, `pixel_count` not incremented, FSM still returns to IDLE. SOF flag retained if the dropped entry carried it.
- Simultaneous FIFO read and write when full: both proceed; no overflow.
- `frame_busy` rising edge: clears `overflow`, `trigger_miss`, `timeout_err`, `pixel_count`. FIFO contents are not flushed.
- `frame_busy` falling mid-conversion: current pixel completes normally.
- Stream: `m_tvalid` = FIFO non-empty. `m_tdata`/`m_tuser`/`m_tlast` come from the head entry and are stable while `m_tvalid`=1 and `m_tready`=0. Pop on `m_tvalid && m_tready`.

## Timing
- Reset values: state IDLE; `adc_convst`, `m_tvalid`, `m_tuser`, `m_tlast`, `overflow`, `trigger_miss`, `timeout_err` = 0; `m_tdata` = 0; `pixel_count` = 0; FIFO empty; SOF flag 0.
- `rst` mid-operation flushes FIFO and aborts conversion on the next edge; no further `adc_convst`.
- Trigger sampled at edge T → `adc_convst` high during cycle T..T+1 (one cycle) → WAIT_DATA from edge T+1.
- Valid sampled at edge E → `m_tvalid` high in the cycle after E (when FIFO was empty).
- Minimum pixel period: 3 cycles (trigger, convst, valid). Back-to-back triggers spaced ≥3 cycles with immediate valid are all accepted.
- Timeout entry is written TIMEOUT_CYCLES cycles after `adc_convst`.

## Configuration
- `CAPTURE_TEST_PATTERN_EN` defined: adds input `test_pattern` (1 bit). While high, CONVERT does not pulse `adc_convst`. It writes {row[7:0], col[7:0]} zero-extended to DATA_W directly to the FIFO and returns to IDLE (2-cycle pixel period). WAIT_DATA is skipped.
- Macro undefined: port absent; ADC path only.

## Test plan
- Reset with `rst`=1 for 4 cycles → all outputs at reset values; no `adc_convst` for 10 triggers while `rst`=1.
- `frame_busy` rise, 3×3 ROI (col_end=2), ADC valid 2 cycles after each convst, `m_tready`=1 → 9 pixels in order; `m_tuser` only on the first; `m_tlast` on pixels 3, 6, 9; `pixel_count`=9.
- `m_tready`=0, 20 pixels, FIFO_DEPTH=16 → 16 stored, `overflow`=1, `pixel_count`=16; releasing ready yields exactly 16 in-order beats.
- ADC never responds → entry 16'hFFFF after 64 cycles, `timeout_err`=1; next `frame_busy` rise clears it.
- Trigger one cycle after an accepted trigger → `trigger_miss`=1; exactly one `adc_convst` pulse.
- With `CAPTURE_TEST_PATTERN_EN`, `test_pattern`=1, row 5 col 7 → `m_tdata`=16'h0507; no `adc_convst`.
